// File: rtl/c64_pkg.sv
// Shared c64 definitions: scan FSM encoding and the reset-fill data pattern,
// used by both the RAM scanner and the reset-fill RAM wrapper.
package c64_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } scan_state_t;

    // Word the reset-fill RAM writes: all-ones-low-bits (width-1) when address bit 2 is set.
    function automatic logic [31:0] fill_pattern(input logic addr_bit2, input int unsigned data_width);
        return addr_bit2 ? 32'(data_width - 1) : 32'd0;
    endfunction

endpackage

// File: rtl/scan_fifo.sv
// Two-entry {addr, data} output buffer for the RAM scanner; head is always
// presented, count tells the owner how full it is.
module scan_fifo #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_idx;
    logic             rd_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= ~wr_idx;
            end
            if (pop)
                rd_idx <= ~rd_idx;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_idx];

endmodule

// File: rtl/ram_scan.sv
// Sequential RAM reader: streams an inclusive, wrapping address range out through
// a valid/ready port and optionally counts words that differ from the fill pattern.
module ram_scan
    import c64_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    input  logic                  check_en,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] mem_do,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           err_count
);

    scan_state_t           state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] end_ptr;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic                  rd_pend;
    logic                  chk;
    logic [1:0]            fifo_count;
    logic [1:0]            free;
    logic                  pop;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] expect_data;

    assign out_addr  = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign out_data  = head[DATA_WIDTH-1:0];
    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid && out_ready;

    // A slot being popped this cycle counts as free, which is what lets the
    // one-cycle read latency sustain one word per cycle.
    assign free   = 2'd2 - fifo_count + {1'b0, pop};
    assign mem_en = (state == S_SCAN) && (free > {1'b0, rd_pend});
    assign mem_a  = rd_ptr;

    assign expect_data = DATA_WIDTH'(fill_pattern(out_addr[2], DATA_WIDTH));

    scan_fifo #(
        .WIDTH(ADDR_WIDTH + DATA_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (rd_pend),
        .push_data({pend_addr, mem_do}),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (reset) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            end_ptr   <= '0;
            pend_addr <= '0;
            rd_pend   <= 1'b0;
            chk       <= 1'b0;
            busy      <= 1'b0;
            err_count <= '0;
        end else begin
            rd_pend <= mem_en;
            if (mem_en)
                pend_addr <= rd_ptr;

            if (pop && chk && (out_data != expect_data) && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_SCAN;
                        rd_ptr    <= start_addr;
                        end_ptr   <= end_addr;
                        chk       <= check_en;
                        busy      <= 1'b1;
                        err_count <= '0;
                    end
                end
                S_SCAN: begin
                    // Pointer parks on the last address so mem_a holds it afterwards.
                    if (mem_en) begin
                        if (rd_ptr == end_ptr)
                            state <= S_DRAIN;
                        else
                            rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!rd_pend && pop && (fifo_count == 2'd1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_scan.sv
// Bench for ram_scan: a synchronous RAM model, a scoreboard of expected words
// filled at start time, and one task per scenario.
module tb_ram_scan;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] end_addr = '0;
    logic        check_en = 1'b0;
    logic [15:0] mem_a;
    logic        mem_en;
    logic [7:0]  mem_do = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [15:0] out_addr;
    logic        busy;
    logic        done;
    logic [15:0] err_count;

    logic [7:0]  ram [0:65535];
    word_t       sb [$];
    int          checks = 0;
    int          fails = 0;

    int          outstanding = 0;
    logic        stalled = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [15:0] prev_addr = '0;

    ram_scan #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .end_addr(end_addr), .check_en(check_en), .mem_a(mem_a), .mem_en(mem_en),
        .mem_do(mem_do), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_en) mem_do <= ram[mem_a];

    // Scoreboard and flow monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            outstanding = 0;
            stalled = 1'b0;
        end else begin
            if (mem_en) outstanding++;
            checks++;
            if (outstanding > 2 + int'(out_valid && out_ready)) begin
                fails++;
                $display("FAIL read_flow: outstanding reads %0d exceed buffer room", outstanding);
            end
            checks++;
            if (mem_en && !busy) begin
                fails++;
                $display("FAIL mem_en_idle: mem_en=1 while busy=0");
            end
            if (stalled) begin
                checks++;
                if (!out_valid || out_data !== prev_data || out_addr !== prev_addr) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b %h@%h, want v=1 %h@%h",
                             out_valid, out_data, out_addr, prev_data, prev_addr);
                end
            end
            if (out_valid && out_ready) begin
                outstanding--;
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got %h@%h, want none", out_data, out_addr);
                end else begin
                    word_t w;
                    w = sb.pop_front();
                    if (out_addr !== w.addr || out_data !== w.data) begin
                        fails++;
                        $display("FAIL word: got %h@%h, want %h@%h", out_data, out_addr, w.data, w.addr);
                    end
                end
            end
            stalled = out_valid && !out_ready;
            prev_data = out_data;
            prev_addr = out_addr;
        end
    end

    // Starts a scan, queues expected words, and waits for done.
    task automatic run_scan(input logic [15:0] sa, input logic [15:0] ea, input logic ce,
                            input logic [31:0] rdy_pat, input int restart_at, input int budget,
                            output bit ok, output int first_acc, output int last_acc,
                            output int done_cyc, output int exp_err);
        logic [15:0] a;
        logic [7:0]  pat;
        ok = 0; first_acc = -1; last_acc = -1; done_cyc = -1; exp_err = 0;
        @(posedge clk); #1;
        a = sa;
        forever begin
            pat = a[2] ? 8'd7 : 8'd0;
            sb.push_back('{addr: a, data: ram[a]});
            if (ce && ram[a] != pat) exp_err++;
            if (a == ea) break;
            a = a + 16'd1;
        end
        start = 1'b1; start_addr = sa; end_addr = ea; check_en = ce; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < budget; i++) begin
            start = (i == restart_at);
            if (i == restart_at) begin
                start_addr = 16'h1000; end_addr = 16'h1003; check_en = ~ce;
            end
            out_ready = (i < 32) ? rdy_pat[i] : 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (first_acc < 0) first_acc = i;
                last_acc = i;
            end
            if (done) begin
                done_cyc = i;
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; start_addr = 16'h0003; end_addr = 16'h0009;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err_count !== 16'd0 ||
            mem_en !== 1'b0 || mem_a !== 16'd0 || out_data !== 8'd0 || out_addr !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: v=%b busy=%b done=%b err=%h en=%b a=%h d=%h oa=%h, want all 0",
                     out_valid, busy, done, err_count, mem_en, mem_a, out_data, out_addr);
        end
    endtask

    task automatic test_basic();
        bit ok; int f, l, d, e;
        run_scan(16'h0000, 16'h000F, 1'b1, 32'hFFFF_FFFF, -1, 60, ok, f, l, d, e);
        checks++;
        if (!ok) begin fails++; $display("FAIL basic_done: no done within budget"); end
        checks++;
        if (f != 2) begin fails++; $display("FAIL basic_latency: first accept cycle %0d, want 2", f); end
        checks++;
        if (l - f != 15) begin fails++; $display("FAIL basic_rate: span %0d, want 15", l - f); end
        checks++;
        if (d != l + 1) begin fails++; $display("FAIL basic_done_time: done %0d, want %0d", d, l + 1); end
        checks++;
        if (err_count !== 16'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_status: err=%h busy=%b, want 0 0", err_count, busy);
        end
        checks++;
        if (sb.size() != 0) begin fails++; $display("FAIL basic_count: %0d words missing, want 0", sb.size()); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: done=%b, want 0", done); end
    endtask

    task automatic test_wrap();
        bit ok; int f, l, d, e;
        run_scan(16'hFFFE, 16'h0001, 1'b1, 32'hFFFF_FFFF, -1, 40, ok, f, l, d, e);
        checks++;
        if (!ok || sb.size() != 0) begin
            fails++; $display("FAIL wrap: done=%0d left=%0d, want 1 0", ok, sb.size());
        end
        checks++;
        if (l - f != 3) begin fails++; $display("FAIL wrap_len: span %0d, want 3", l - f); end
    endtask

    task automatic test_single();
        bit ok; int f, l, d, e;
        run_scan(16'h0014, 16'h0014, 1'b1, 32'hFFFF_FFFF, -1, 40, ok, f, l, d, e);
        checks++;
        if (!ok || sb.size() != 0 || l != f) begin
            fails++; $display("FAIL single: done=%0d left=%0d span=%0d, want 1 0 0", ok, sb.size(), l - f);
        end
    endtask

    task automatic test_stall();
        bit ok; int f, l, d, e;
        run_scan(16'h0020, 16'h002F, 1'b1, 32'hFFFF_F817, -1, 100, ok, f, l, d, e);
        checks++;
        if (!ok || sb.size() != 0) begin
            fails++; $display("FAIL stall: done=%0d left=%0d, want 1 0", ok, sb.size());
        end
        checks++;
        if (err_count !== 16'd0) begin fails++; $display("FAIL stall_err: err=%h, want 0", err_count); end
    endtask

    task automatic test_check();
        bit ok; int f, l, d, e;
        ram[16'h0005] = 8'h00;
        run_scan(16'h0000, 16'h0007, 1'b1, 32'hFFFF_FFFF, -1, 40, ok, f, l, d, e);
        checks++;
        if (!ok || err_count !== 16'd1 || sb.size() != 0) begin
            fails++; $display("FAIL check_on: done=%0d err=%h, want 1 0001", ok, err_count);
        end
        run_scan(16'h0000, 16'h0007, 1'b0, 32'hFFFF_FFFF, -1, 40, ok, f, l, d, e);
        checks++;
        if (!ok || err_count !== 16'd0 || sb.size() != 0) begin
            fails++; $display("FAIL check_off: done=%0d err=%h, want 1 0000", ok, err_count);
        end
        ram[16'h0005] = 8'h07;
    endtask

    task automatic test_reset_mid();
        bit ok; int f, l, d, e;
        ram[16'h0040] = 8'h5A;
        @(posedge clk); #1;
        for (int a = 16'h40; a <= 16'h4F; a++) sb.push_back('{addr: 16'(a), data: ram[a]});
        start = 1'b1; start_addr = 16'h0040; end_addr = 16'h004F; check_en = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (err_count !== 16'd1) begin fails++; $display("FAIL mid_pre_err: err=%h, want 0001", err_count); end
        @(posedge clk); #1 reset = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || err_count !== 16'd0 || mem_en !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: v=%b busy=%b err=%h en=%b, want 0 0 0 0", out_valid, busy, err_count, mem_en);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_discard: out_valid=%b, want 0", out_valid); end
        ram[16'h0040] = 8'h00;
        run_scan(16'h0040, 16'h0047, 1'b1, 32'hFFFF_FFFF, -1, 40, ok, f, l, d, e);
        checks++;
        if (!ok || sb.size() != 0 || err_count !== 16'd0) begin
            fails++; $display("FAIL mid_rescan: done=%0d left=%0d err=%h, want 1 0 0", ok, sb.size(), err_count);
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int f, l, d, e;
        ram[16'h1001] = 8'hEE;
        run_scan(16'h0080, 16'h0087, 1'b1, 32'hFFFF_FFFF, 3, 40, ok, f, l, d, e);
        checks++;
        if (!ok || sb.size() != 0 || l - f != 7 || err_count !== 16'd0) begin
            fails++;
            $display("FAIL busy_start: done=%0d left=%0d span=%0d err=%h, want 1 0 7 0", ok, sb.size(), l - f, err_count);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL busy_start_idle: busy=%b v=%b, want 0 0", busy, out_valid);
        end
        ram[16'h1001] = 8'h00;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] av;
            av = 16'(a);
            ram[a] = av[2] ? 8'd7 : 8'd0;
        end
        test_reset();
        test_basic();
        test_wrap();
        test_single();
        test_stall();
        test_check();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
